// File: rtl/cond_pkg.sv
// Shared encodings for the conditional-execution stage: condition codes,
// ALU operations, NZCV bit positions and the captured decoder control bundle.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b110;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

   typedef struct packed {
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       memtoreg;
      logic       alusrc;
      logic       byte_op;
      logic       branch;
      logic [1:0] flagw;
      logic [2:0] alucontrol;
   } ex_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against NZCV flags.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v, ge;

   always_comb begin
      n       = flags[FLAG_N];
      z       = flags[FLAG_Z];
      c       = flags[FLAG_C];
      v       = flags[FLAG_V];
      ge      = (n == v);
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = ge;
         COND_LT: cond_ex = ~ge;
         COND_GT: cond_ex = ~z & ge;
         COND_LE: cond_ex = z | ~ge;
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_exec_stage.sv
// ID/EX register with the NZCV flag register and condition-gated write enables.
// Define COND_STATS_EN to count instructions annulled by a failing condition.
module cond_exec_stage
   import cond_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic [3:0]       cond_d,
   input  logic             pcs_d,
   input  logic             regw_d,
   input  logic             memw_d,
   input  logic             memtoreg_d,
   input  logic             alusrc_d,
   input  logic             byte_d,
   input  logic             branch_d,
   input  logic [1:0]       flagw_d,
   input  logic [2:0]       alucontrol_d,
   input  logic [3:0]       aluflags_e,
   output logic             pcsrc_e,
   output logic             regwrite_e,
   output logic             memwrite_e,
   output logic             branch_taken_e,
   output logic             memtoreg_e,
   output logic             alusrc_e,
   output logic             byte_e,
   output logic [2:0]       alucontrol_e,
   output logic [3:0]       flags,
   output logic             cond_ex_e,
   output logic [CNT_W-1:0] annul_count
);

   ex_ctrl_t   ctrl_d;
   ex_ctrl_t   ctrl_reg;
   logic [3:0] cond_e_reg;
   logic       valid_e_reg;
   logic [3:0] flags_reg;
   logic       cond_ex;
   logic       exec_ok;

   assign ctrl_d = '{pcs: pcs_d, regw: regw_d, memw: memw_d, memtoreg: memtoreg_d,
                     alusrc: alusrc_d, byte_op: byte_d, branch: branch_d,
                     flagw: flagw_d, alucontrol: alucontrol_d};

   // A flushed slot becomes an AL bubble so it can never be counted as annulled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_reg    <= '0;
         cond_e_reg  <= COND_AL;
         valid_e_reg <= 1'b0;
      end else if (flush_e) begin
         ctrl_reg    <= '0;
         cond_e_reg  <= COND_AL;
         valid_e_reg <= 1'b0;
      end else if (!stall_e) begin
         ctrl_reg    <= ctrl_d;
         cond_e_reg  <= cond_d;
         valid_e_reg <= 1'b1;
      end
   end

   cond_check u_cond_check (
      .cond    (cond_e_reg),
      .flags   (flags_reg),
      .cond_ex (cond_ex)
   );

   assign exec_ok = cond_ex & valid_e_reg;

   // Frozen during stall so a held instruction writes its flags exactly once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_reg <= '0;
      end else if (!stall_e) begin
         if (ctrl_reg.flagw[FLAGW_NZ] && exec_ok)
            flags_reg[FLAG_N:FLAG_Z] <= aluflags_e[FLAG_N:FLAG_Z];
         if (ctrl_reg.flagw[FLAGW_CV] && exec_ok)
            flags_reg[FLAG_C:FLAG_V] <= aluflags_e[FLAG_C:FLAG_V];
      end
   end

   assign pcsrc_e        = ctrl_reg.pcs    & exec_ok;
   assign regwrite_e     = ctrl_reg.regw   & exec_ok;
   assign memwrite_e     = ctrl_reg.memw   & exec_ok;
   assign branch_taken_e = ctrl_reg.branch & exec_ok;
   assign memtoreg_e     = ctrl_reg.memtoreg;
   assign alusrc_e       = ctrl_reg.alusrc;
   assign byte_e         = ctrl_reg.byte_op;
   assign alucontrol_e   = ctrl_reg.alucontrol;
   assign flags          = flags_reg;
   assign cond_ex_e      = cond_ex;

`ifdef COND_STATS_EN
   logic [CNT_W-1:0] annul_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         annul_reg <= '0;
      else if (valid_e_reg && !cond_ex && !stall_e)
         annul_reg <= annul_reg + CNT_W'(1);
   end

   assign annul_count = annul_reg;
`else
   assign annul_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Scoreboard bench for cond_exec_stage: stimulus queues expected outputs,
// a monitor compares them one cycle after each captured transaction.
module tb_cond_exec_stage;
   import cond_pkg::*;

`ifdef COND_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk, reset, stall_e, flush_e;
   logic [3:0] cond_d, aluflags_e, flags, annul_count;
   logic       pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d, byte_d, branch_d;
   logic [1:0] flagw_d;
   logic [2:0] alucontrol_d, alucontrol_e;
   logic       pcsrc_e, regwrite_e, memwrite_e, branch_taken_e;
   logic       memtoreg_e, alusrc_e, byte_e, cond_ex_e;

   cond_exec_stage #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
      .cond_d(cond_d), .pcs_d(pcs_d), .regw_d(regw_d), .memw_d(memw_d),
      .memtoreg_d(memtoreg_d), .alusrc_d(alusrc_d), .byte_d(byte_d),
      .branch_d(branch_d), .flagw_d(flagw_d), .alucontrol_d(alucontrol_d),
      .aluflags_e(aluflags_e), .pcsrc_e(pcsrc_e), .regwrite_e(regwrite_e),
      .memwrite_e(memwrite_e), .branch_taken_e(branch_taken_e),
      .memtoreg_e(memtoreg_e), .alusrc_e(alusrc_e), .byte_e(byte_e),
      .alucontrol_e(alucontrol_e), .flags(flags), .cond_ex_e(cond_ex_e),
      .annul_count(annul_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   string       nq[$];
   logic [18:0] vq[$];

   // Model of the EX slot for pass-through fields and the annul counter.
   logic [2:0] m_pass;
   logic [2:0] m_ac;
   logic       m_valid, m_cex;
   logic [3:0] m_annul;

   function automatic logic [18:0] act_vec();
      return {pcsrc_e, regwrite_e, memwrite_e, branch_taken_e,
              memtoreg_e, alusrc_e, byte_e, alucontrol_e,
              flags, cond_ex_e, annul_count};
   endfunction

   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v;
      {n, z, cc, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cc;
         4'h3: return !cc;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cc && !z;
         4'h9: return !cc || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %05h want %05h", nm, act, exp);
      end else begin
         $display("txn %0d %s ok outputs=%05h", total, nm, act);
      end
   endtask

   task automatic idle();
      {pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d, byte_d, branch_d} = 7'b0;
      flagw_d = 2'b00; alucontrol_d = ALU_ADD; cond_d = COND_AL;
      aluflags_e = 4'h0; stall_e = 1'b0; flush_e = 1'b0;
   endtask

   // c7 = {pcs, regw, memw, memtoreg, alusrc, byte, branch}; eg = {pcsrc, regwrite, memwrite, branch_taken}
   task automatic step(input string nm, input logic [6:0] c7, input logic [1:0] fw,
                       input logic [2:0] ac, input logic [3:0] cd, input logic [3:0] alf,
                       input logic st, input logic fl, input logic [3:0] eg,
                       input logic [3:0] ef, input logic ec);
      @(negedge clk);
      {pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d, byte_d, branch_d} = c7;
      flagw_d = fw; alucontrol_d = ac; cond_d = cd;
      aluflags_e = alf; stall_e = st; flush_e = fl;
      if (m_valid && !m_cex && !st) m_annul = m_annul + 4'd1;
      if (fl) begin
         m_pass = 3'b0; m_ac = 3'b0; m_valid = 1'b0;
      end else if (!st) begin
         m_pass = c7[3:1]; m_ac = ac; m_valid = 1'b1;
      end
      m_cex = ec;
      nq.push_back(nm);
      vq.push_back({eg, m_pass, m_ac, ef, ec, (STATS ? m_annul : 4'd0)});
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 chk(nm, act_vec(), {4'b0, 3'b0, 3'b0, 4'b0, 1'b1, 4'b0});
      idle();
      @(negedge clk) reset = 1'b0;
      m_pass = 3'b0; m_ac = 3'b0; m_valid = 1'b0; m_cex = 1'b1; m_annul = 4'd0;
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (vq.size() > 0) chk(nq.pop_front(), act_vec(), vq.pop_front());
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [3:0] cur_flags;
      logic       cx;
      reset = 1'b1;
      idle();
      m_pass = 3'b0; m_ac = 3'b0; m_valid = 1'b0; m_cex = 1'b1; m_annul = 4'd0;
      repeat (2) @(posedge clk);
      #1 chk("reset_init", act_vec(), {4'b0, 3'b0, 3'b0, 4'b0, 1'b1, 4'b0});
      @(negedge clk) reset = 1'b0;

      // Drive flags to 1111, then reset mid-operation.
      step("cmp_set",  7'b0, 2'b11, ALU_SUB, COND_AL, 4'h0, 0, 0, 4'b0000, 4'b0000, 1);
      step("cmp_upd",  7'b0, 2'b00, ALU_ADD, COND_AL, 4'hF, 0, 0, 4'b0000, 4'b1111, 1);
      do_reset("reset_mid");

      // SUBS sets Z and C; following BEQ branches.
      step("subs",     7'b0100000, 2'b11, ALU_SUB, COND_AL, 4'h0, 0, 0, 4'b0100, 4'b0000, 1);
      step("beq",      7'b1000001, 2'b00, ALU_ADD, COND_EQ, 4'b0110, 0, 0, 4'b1001, 4'b0110, 1);

      // Failing EQ: no register, memory or flag write.
      step("cmp0",     7'b0, 2'b11, ALU_SUB, COND_AL, 4'hF, 0, 0, 4'b0000, 4'b0110, 1);
      step("eq_fail",  7'b0110000, 2'b11, ALU_ADD, COND_EQ, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
      step("after_fail", 7'b0, 2'b00, ALU_ADD, COND_AL, 4'hF, 0, 0, 4'b0000, 4'b0000, 1);

      // Flush beats stall; stall alone holds EX and freezes flags.
      step("ld_stall", 7'b0101110, 2'b11, ALU_AND, COND_AL, 4'h0, 0, 0, 4'b0100, 4'b0000, 1);
      step("stall_flush", 7'b0100000, 2'b00, ALU_ADD, COND_AL, 4'b1010, 1, 1, 4'b0000, 4'b0000, 1);
      step("ld2",      7'b0101110, 2'b11, ALU_EOR, COND_AL, 4'h0, 0, 0, 4'b0100, 4'b0000, 1);
      step("hold1",    7'b1000000, 2'b00, ALU_ADD, COND_EQ, 4'hF, 1, 0, 4'b0100, 4'b0000, 1);
      step("hold2",    7'b1000000, 2'b00, ALU_ADD, COND_EQ, 4'b1010, 1, 0, 4'b0100, 4'b0000, 1);
      step("hold3",    7'b1000000, 2'b00, ALU_ADD, COND_EQ, 4'b0101, 1, 0, 4'b0100, 4'b0000, 1);
      step("release",  7'b0, 2'b00, ALU_ADD, COND_AL, 4'b1001, 0, 0, 4'b0000, 4'b1001, 1);

      // Independent NZ and CV halves.
      step("set0011",  7'b0, 2'b11, ALU_SUB, COND_AL, 4'hF, 0, 0, 4'b0000, 4'b1001, 1);
      step("nzonly",   7'b0, 2'b10, ALU_SUB, COND_AL, 4'b0011, 0, 0, 4'b0000, 4'b0011, 1);
      step("nz_apply", 7'b0, 2'b01, ALU_ADD, COND_AL, 4'b1000, 0, 0, 4'b0000, 4'b1011, 1);
      step("cv_apply", 7'b0, 2'b00, ALU_ADD, COND_AL, 4'b0100, 0, 0, 4'b0000, 4'b1000, 1);

      // Every condition code against every flag value.
      cur_flags = 4'b1000;
      for (int f = 0; f < 16; f++) begin
         step($sformatf("ld_f%0h", f), 7'b0, 2'b11, ALU_SUB, COND_AL, 4'h0, 0, 0,
              4'b0000, cur_flags, 1);
         for (int c = 0; c < 16; c++) begin
            cx = cond_ref(4'(c), 4'(f));
            step($sformatf("sweep_c%0h_f%0h", c, f), 7'b0100000, 2'b00, ALU_ADD, 4'(c),
                 (c == 0) ? 4'(f) : ~4'(f), 0, 0, {1'b0, cx, 2'b00}, 4'(f), cx);
         end
         cur_flags = 4'(f);
      end

      // 17 annulled instructions wrap a 4-bit counter to 1.
      do_reset("reset_wrap");
      for (int i = 0; i < 17; i++)
         step($sformatf("nv_%0d", i), 7'b0100000, 2'b11, ALU_ADD, COND_NV, 4'hF, 0, 0,
              4'b0000, 4'b0000, 0);
      step("nv_done", 7'b0, 2'b00, ALU_ADD, COND_AL, 4'hF, 0, 0, 4'b0000, 4'b0000, 1);
      @(posedge clk);
      #2;
      chk("annul_wrap", {15'b0, annul_count}, {15'b0, (STATS ? 4'd1 : 4'd0)});
      total++;
      if (vq.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending want 0", vq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- ID/EX pipeline register plus conditional-execution logic.
- Sits directly downstream of the instruction decoder. Captures its control outputs and the instruction condition field, holds the NZCV flag register, and evaluates the condition.
- Gates PC-write, register-write, memory-write and flag-write for the execute stage.
- Feeds the hazard unit, the datapath writeback path and the memory stage.

Parameters:
- CNT_W, 16, width of the annulled-instruction counter (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall_e  in  1  hold the EX register contents
- flush_e  in  1  insert a bubble into EX
- cond_d  in  4  instruction bits [31:28]
- pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d, byte_d, branch_d  in  1 each  decoder controls
- flagw_d  in  2  decoder FlagW; [1] selects NZ, [0] selects CV
- alucontrol_d  in  3  decoder ALUControl
- aluflags_e  in  4  NZCV from the EX-stage ALU, ordered {N,Z,C,V}
- pcsrc_e, regwrite_e, memwrite_e, branch_taken_e  out  1  condition-gated controls
- memtoreg_e, alusrc_e, byte_e  out  1  registered pass-through controls
- alucontrol_e  out  3  registered pass-through
- flags  out  4  current NZCV register
- cond_ex_e  out  1  condition passed for the EX instruction
- annul_count  out  CNT_W  count of annulled instructions

Behaviour:
- **Reset (async):** all EX registers clear to 0, cond_e is set to 4'hE, valid_e is 0, flags are 0, and annul_count is 0. Every output is therefore 0 during reset, except cond_ex_e, which is 1 because the condition is AL; all gated outputs are still 0.
- **EX register priority at each clk rising edge:**
  - flush_e has priority over stall_e. A flush clears all control bits and valid_e and sets cond_e to 4'hE.
  - Otherwise stall_e holds every EX register.
  - Otherwise the register captures the *_d inputs and sets valid_e to 1.
- **Latency:** a decoder output presented in cycle n appears on the *_e outputs in cycle n+1.
- **Condition evaluation:** combinational from cond_e and the flags register.
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C & ~Z
  - 9 LS: ~C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z & (N==V)
  - D LE: Z | (N!=V)
  - E AL: 1
  - F: 0 (never execute)
- **Gating:**
  - pcsrc_e = pcs_e & cond_ex_e
  - regwrite_e = regw_e & cond_ex_e
  - memwrite_e = memw_e & cond_ex_e
  - branch_taken_e = branch_e & cond_ex_e
- **Flag update at the rising edge**, only when stall_e is 0:
  - If flagw_e[1] & cond_ex_e, then flags[3:2] <= aluflags_e[3:2].
  - If flagw_e[0] & cond_ex_e, then flags[1:0] <= aluflags_e[1:0].
  - The two halves are independent.
- **Flag visibility:** updated flags are visible to the next instruction's condition in the next cycle. There is no same-cycle flag forwarding.
- **Stall and flags:** while stall_e is high, flags are frozen, so a held instruction never updates flags twice.
- **Bubbles:** a bubble (valid_e=0) never writes anything, because its controls are 0.

Optional Feature:
- Macro: COND_STATS_EN.
- **With the macro:** annul_count increments by 1 on each rising edge where valid_e & ~cond_ex_e & ~stall_e. It wraps modulo 2^CNT_W.
- **Without the macro:** the counter logic is omitted and annul_count is tied to 0. The port remains present.

Decomposition:
- **Package cond_pkg:**
  - Condition-code localparams COND_EQ..COND_NV (4'h0..4'hF).
  - ALUControl encodings: ADD 3'b000, SUB 3'b001, AND 3'b010, ORR 3'b011, EOR 3'b110.
  - Flag bit indices: N=3, Z=2, C=1, V=0.
  - FlagW bit meanings: NZ=1, CV=0.
- **Sub-module cond_check:** combinational; inputs cond[3:0] and flags[3:0]; output cond_ex.

Test Plan:
- **Reset with flags set:** assert reset mid-operation with flags=4'b1111 → flags=0, all gated outputs 0, annul_count=0 immediately, without waiting for a clock edge.
- **SUBS then BEQ:** SUBS with flagw_d=2'b11 and aluflags_e=4'b0110 → flags=4'b0110 next cycle. A following BEQ (cond 0, branch_d=1, pcs_d=1) → branch_taken_e=1, pcsrc_e=1.
- **Condition fails:** flags=4'b0000 and a cond 0 instruction with regw_d=1, memw_d=1, flagw_d=2'b11 → regwrite_e=0, memwrite_e=0, flags unchanged. With COND_STATS_EN, annul_count goes 0→1.
- **Stall/flush priority:** stall_e=1 and flush_e=1 together with regw_d=1 → next cycle regwrite_e=0 and valid_e=0. stall_e alone → all *_e outputs held for 3 cycles, and flags do not change despite flagw_e=2'b11.
- **Partial flag write:** flagw_d=2'b10 (NZ only) with flags=4'b0011 and aluflags_e=4'b1000 → flags=4'b1011.
- **Sweep and wrap:** sweep all 16 cond codes against all 16 flag values → cond_ex_e matches the table, including F→0 and E→1. With CNT_W=4, 17 annuls → annul_count=1.
